bram_arbiter: RTL and testbench

Arbitrates a single BRAM_IF transaction port among NREQ requesters (AXI slave, AES key/data reader, AES result writer). Sequences BRAM_IF's four-phase start/complete handshake and returns read data or readback. A watchdog aborts transactions that never complete. Sits between the requesters and BRAM_IF on axi_clk.

---
 rtl/bram_arb_pkg.sv | 20 ++
 rtl/bram_arbiter_rr_arbiter.sv | 28 ++
 rtl/bram_arbiter.sv | 145 ++++++++++++++
 tb/tb_bram_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// rtl/bram_arb_pkg.sv - shared types and constants for the BRAM_IF arbiter
package bram_arb_pkg;

   // Transaction sequencer states around the BRAM_IF four-phase handshake
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_RELEASE = 2'd2,
      ST_DONE    = 2'd3
   } arb_state_t;

   // Cycles allowed in each wait state before the watchdog aborts
   localparam int DEFAULT_TIMEOUT = 256;

   // Requester slots on the arbiter
   localparam int REQ_AXI    = 0;
   localparam int REQ_AES_RD = 1;
   localparam int REQ_AES_WR = 2;

endpackage

// File: rtl/bram_arbiter_rr_arbiter.sv
// rtl/bram_arbiter_rr_arbiter.sv - combinational rotate-priority requester search
module rr_arbiter #(
   parameter int NREQ = 3,
   parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last_grant,
   output logic [IW-1:0]   grant,
   output logic            any
);

   logic [IW-1:0] idx;

   // Walk from the farthest slot back toward last_grant+1 so the nearest set bit wins
   always_comb begin
      grant = '0;
      any   = 1'b0;
      idx   = '0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = IW'((32'(last_grant) + 32'(k)) % NREQ);
         if (req[idx]) begin
            grant = idx;
            any   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bram_arbiter.sv
// rtl/bram_arbiter.sv - round-robin arbiter sequencing BRAM_IF transactions with watchdog
module bram_arbiter
   import bram_arb_pkg::*;
#(
   parameter int NREQ    = 3,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic             axi_clk,
   input  logic             axi_rst,
   input  logic [NREQ-1:0]  req,
   input  logic [NREQ-1:0]  req_we,
   input  logic [NREQ*32-1:0] req_addr,
   input  logic [NREQ*32-1:0] req_wdata,
   output logic [NREQ-1:0]  ack,
   output logic [NREQ-1:0]  err,
   output logic [31:0]      rdata,
   output logic             busy,
   output logic             bif_start_read,
   output logic             bif_start_write,
   output logic [31:0]      bif_addr,
   output logic [31:0]      bif_wdata,
   input  logic             bif_complete,
   input  logic [31:0]      bif_rdata
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int WW = $clog2(TIMEOUT);
   localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT - 1);
   localparam logic [IW-1:0] LAST_INIT = IW'(NREQ - 1);

   arb_state_t      state;
   logic [IW-1:0]   last_grant;
   logic [IW-1:0]   grant;
   logic [IW-1:0]   pick;
   logic            pick_valid;
   logic [WW-1:0]   wd;
   logic            wd_expired;
   logic [NREQ-1:0] grant_onehot;
   logic [31:0]     sel_addr;
   logic [31:0]     sel_wdata;
   logic            sel_we;

   rr_arbiter #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_rr (
      .req        (req),
      .last_grant (last_grant),
      .grant      (pick),
      .any        (pick_valid)
   );

   assign wd_expired   = (wd == WD_LAST);
   assign grant_onehot = NREQ'(1) << grant;

   // Pull the chosen requester's address, data and direction out of the packed buses
   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_we    = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick == IW'(i)) begin
            sel_addr  = req_addr[32*i +: 32];
            sel_wdata = req_wdata[32*i +: 32];
            sel_we    = req_we[i];
         end
      end
   end

   // Transaction sequencer: grant, four-phase handshake, watchdog abort, one-cycle ack
   always_ff @(posedge axi_clk or posedge axi_rst) begin
      if (axi_rst) begin
         state           <= ST_IDLE;
         last_grant      <= LAST_INIT;
         grant           <= '0;
         wd              <= '0;
         ack             <= '0;
         err             <= '0;
         rdata           <= '0;
         busy            <= 1'b0;
         bif_start_read  <= 1'b0;
         bif_start_write <= 1'b0;
         bif_addr        <= '0;
         bif_wdata       <= '0;
      end else begin
         ack <= '0;
         err <= '0;
         case (state)
            ST_IDLE: begin
               if (pick_valid) begin
                  // bif_addr/bif_wdata double as the holding registers, so
                  // requester bus changes after this edge cannot disturb the transfer
                  grant           <= pick;
                  bif_addr        <= sel_addr;
                  bif_wdata       <= sel_wdata;
                  bif_start_read  <= ~sel_we;
                  bif_start_write <= sel_we;
                  wd              <= '0;
                  busy            <= 1'b1;
                  state           <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (bif_complete) begin
                  rdata           <= bif_rdata;
                  bif_start_read  <= 1'b0;
                  bif_start_write <= 1'b0;
                  wd              <= '0;
                  state           <= ST_RELEASE;
               end else if (wd_expired) begin
                  bif_start_read  <= 1'b0;
                  bif_start_write <= 1'b0;
                  ack             <= grant_onehot;
                  err             <= grant_onehot;
                  state           <= ST_DONE;
               end else begin
                  wd <= wd + 1'b1;
               end
            end
            ST_RELEASE: begin
               if (!bif_complete) begin
                  ack   <= grant_onehot;
                  state <= ST_DONE;
               end else if (wd_expired) begin
                  ack   <= grant_onehot;
                  err   <= grant_onehot;
                  state <= ST_DONE;
               end else begin
                  wd <= wd + 1'b1;
               end
            end
            ST_DONE: begin
               last_grant <= grant;
               busy       <= 1'b0;
               state      <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bram_arbiter.sv
// tb/tb_bram_arbiter.sv - scoreboard bench for bram_arbiter with a BRAM_IF model
module tb_bram_arbiter;
   import bram_arb_pkg::*;

   localparam int NREQ = 3;

   logic               axi_clk = 1'b0;
   logic               axi_rst;
   logic [NREQ-1:0]    req, req_we, ack, err;
   logic [NREQ*32-1:0] req_addr, req_wdata;
   logic [31:0]        rdata, bif_addr, bif_wdata, bif_rdata;
   logic               busy, bif_start_read, bif_start_write, bif_complete;

   typedef struct {
      int          idx;
      logic [31:0] data;
      logic        e;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        cur;
   logic [NREQ-1:0] oh;
   int          n_checks = 0;
   int          n_fails  = 0;
   int          n_tx     = 0;
   int          persist [NREQ];
   logic        ack_d = 1'b0;
   logic        model_hang = 1'b0;
   int          model_lat = 1;
   int          lat_cnt = 0;
   logic        saw_read = 1'b0, saw_write = 1'b0;
   logic [31:0] mem [logic [31:0]];

   bram_arbiter #(.NREQ(NREQ), .TIMEOUT(16)) dut (
      .axi_clk         (axi_clk),
      .axi_rst         (axi_rst),
      .req             (req),
      .req_we          (req_we),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .ack             (ack),
      .err             (err),
      .rdata           (rdata),
      .busy            (busy),
      .bif_start_read  (bif_start_read),
      .bif_start_write (bif_start_write),
      .bif_addr        (bif_addr),
      .bif_wdata       (bif_wdata),
      .bif_complete    (bif_complete),
      .bif_rdata       (bif_rdata)
   );

   always #5 axi_clk = ~axi_clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      n_checks++;
      if (act !== want) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, want);
      end
   endtask

   task automatic push_exp(input int idx, input logic [31:0] d, input logic e);
      exp_t x;
      x.idx = idx; x.data = d; x.e = e;
      exp_q.push_back(x);
   endtask

   task automatic set_req(input int i, input logic we, input logic [31:0] a, input logic [31:0] d);
      req_we[i]            = we;
      req_addr[32*i +: 32]  = a;
      req_wdata[32*i +: 32] = d;
      req[i]               = 1'b1;
   endtask

   task automatic wait_drain(input int budget, input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge axi_clk);
         n++;
      end
      check({name, "_drain"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      repeat (2) @(negedge axi_clk);
   endtask

   // BRAM_IF model: raise complete on negedge after model_lat cycles, drop once start is gone
   always @(negedge axi_clk) begin
      if (bif_start_read || bif_start_write) begin
         if (!model_hang) begin
            if (lat_cnt >= model_lat) begin
               if (bif_start_write) mem[bif_addr] = bif_wdata;
               bif_rdata    = mem.exists(bif_addr) ? mem[bif_addr] : 32'h0;
               bif_complete = 1'b1;
            end else begin
               lat_cnt++;
            end
         end
      end else begin
         bif_complete = 1'b0;
         lat_cnt      = 0;
      end
      if (bif_start_read)  saw_read  = 1'b1;
      if (bif_start_write) saw_write = 1'b1;
   end

   // Requesters drop req when acked unless told to hold for further transactions
   always @(negedge axi_clk) begin
      for (int i = 0; i < NREQ; i++) begin
         if (ack[i]) begin
            if (persist[i] > 0) persist[i]--;
            else req[i] = 1'b0;
         end
      end
   end

   // Monitor: pop one expectation per ack and check the idle gap after each ack
   always @(negedge axi_clk) begin
      if (axi_rst) begin
         ack_d = 1'b0;
      end else begin
         if (ack_d) check($sformatf("idle_after_ack%0d", n_tx), 64'(busy), 64'd0);
         if (ack != '0 || err != '0) begin
            if (exp_q.size() == 0) begin
               check("unexpected_ack", 64'(ack), 64'd0);
            end else begin
               cur = exp_q.pop_front();
               oh = '0;
               oh[cur.idx] = 1'b1;
               check($sformatf("ack%0d_grant", n_tx), 64'(ack), 64'(oh));
               check($sformatf("ack%0d_err", n_tx), 64'(err), cur.e ? 64'(oh) : 64'd0);
               check($sformatf("ack%0d_rdata", n_tx), 64'(rdata), 64'(cur.data));
            end
            n_tx++;
         end
         ack_d = (ack != '0);
      end
   end

   initial begin
      int n;
      int cnt;
      axi_rst      = 1'b1;
      req          = '0;
      req_we       = '0;
      req_addr     = '0;
      req_wdata    = '0;
      bif_complete = 1'b0;
      bif_rdata    = '0;
      for (int i = 0; i < NREQ; i++) persist[i] = 0;
      mem[32'h10] = 32'hCAFEBABE;
      repeat (3) @(negedge axi_clk);
      axi_rst = 1'b0;
      @(negedge axi_clk);
      check("reset_outputs",
            64'({ack, err, rdata, busy, bif_start_read, bif_start_write}), 64'd0);
      check("reset_bif_addr", 64'({bif_addr, bif_wdata}), 64'd0);

      // Single read of 0x10 with latency bound
      push_exp(REQ_AXI, 32'hCAFEBABE, 1'b0);
      set_req(REQ_AXI, 1'b0, 32'h10, 32'h0);
      n = 0;
      while (ack[REQ_AXI] !== 1'b1 && n < 20) begin
         @(negedge axi_clk);
         n++;
      end
      check("read_latency_le12", 64'(n <= 12), 64'd1);
      wait_drain(20, "single_read");

      // Write with readback; only the write strobe may appear
      saw_read = 1'b0; saw_write = 1'b0;
      push_exp(REQ_AES_WR, 32'h12345678, 1'b0);
      set_req(REQ_AES_WR, 1'b1, 32'h20, 32'h12345678);
      wait_drain(20, "write");
      check("write_no_read_strobe", 64'(saw_read), 64'd0);
      check("write_strobe_seen", 64'(saw_write), 64'd1);

      // Round robin: all three held for two transactions each
      for (int r = 0; r < 2; r++) begin
         push_exp(REQ_AXI,    32'hCAFEBABE, 1'b0);
         push_exp(REQ_AES_RD, 32'h12345678, 1'b0);
         push_exp(REQ_AES_WR, 32'hA5A50001, 1'b0);
      end
      for (int i = 0; i < NREQ; i++) persist[i] = 1;
      set_req(REQ_AXI,    1'b0, 32'h10, 32'h0);
      set_req(REQ_AES_RD, 1'b0, 32'h20, 32'h0);
      set_req(REQ_AES_WR, 1'b1, 32'h30, 32'hA5A50001);
      wait_drain(120, "round_robin");

      // Read back the word written earlier
      push_exp(REQ_AXI, 32'h12345678, 1'b0);
      set_req(REQ_AXI, 1'b0, 32'h20, 32'h0);
      wait_drain(20, "readback");

      // Watchdog abort: start high 16 cycles, err with ack, rdata unchanged
      model_hang = 1'b1;
      push_exp(REQ_AES_RD, 32'h12345678, 1'b1);
      set_req(REQ_AES_RD, 1'b0, 32'h40, 32'h0);
      n = 0;
      while (!bif_start_read && n < 10) begin
         @(negedge axi_clk);
         n++;
      end
      cnt = 0;
      while (bif_start_read && cnt < 40) begin
         cnt++;
         @(negedge axi_clk);
      end
      check("timeout_start_cycles", 64'(cnt), 64'd16);
      wait_drain(20, "timeout");
      model_hang = 1'b0;

      // Late drop: requester 1 holds req one cycle past ack, gets a second transaction
      persist[REQ_AES_RD] = 1;
      push_exp(REQ_AES_RD, 32'hCAFEBABE, 1'b0);
      push_exp(REQ_AES_RD, 32'hCAFEBABE, 1'b0);
      set_req(REQ_AES_RD, 1'b0, 32'h10, 32'h0);
      wait_drain(40, "late_drop");

      // Reset in ISSUE: outputs drop at once, no ack
      model_hang = 1'b1;
      set_req(REQ_AXI, 1'b0, 32'h10, 32'h0);
      n = 0;
      while (!bif_start_read && n < 10) begin
         @(negedge axi_clk);
         n++;
      end
      check("rst_reached_issue", 64'(bif_start_read), 64'd1);
      axi_rst = 1'b1;
      #1;
      check("rst_start_low", 64'({bif_start_read, bif_start_write}), 64'd0);
      check("rst_ack_low", 64'(ack), 64'd0);
      check("rst_busy_low", 64'(busy), 64'd0);
      req = '0;
      repeat (2) @(negedge axi_clk);
      axi_rst = 1'b0;
      model_hang = 1'b0;
      @(negedge axi_clk);

      // After reset requester 0 wins over requester 1
      push_exp(REQ_AXI,    32'h12345678, 1'b0);
      push_exp(REQ_AES_RD, 32'hCAFEBABE, 1'b0);
      set_req(REQ_AXI,    1'b0, 32'h20, 32'h0);
      set_req(REQ_AES_RD, 1'b0, 32'h10, 32'h0);
      wait_drain(40, "post_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
